// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM stage: FSM encoding, control-bit positions
// and the default memory-access timeout.
package mem_wb_stage_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam int M_READ_BIT      = 1;
    localparam int M_WRITE_BIT     = 0;
    localparam int WB_REGWRITE_BIT = 1;
    localparam int WB_MEMTOREG_BIT = 0;

    localparam int TIMEOUT_DEFAULT = 15;
    localparam int CNT_W           = 4;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register bank; a bubble clears the write-back controls so
// the WB stage performs no register write.
module mem_wb_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] read_data,
    input  logic [31:0] alu_result,
    input  logic [4:0]  addr,
    input  logic [1:0]  wb,
    output logic [31:0] mem_wb_read_data,
    output logic [31:0] mem_wb_alu_result,
    output logic [4:0]  mem_wb_addr,
    output logic [1:0]  mem_wb_wb
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the async reset sits in the sensitivity list.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_wb_read_data  <= '0;
            mem_wb_alu_result <= '0;
            mem_wb_addr       <= '0;
            mem_wb_wb         <= '0;
        end else if (bubble) begin
            mem_wb_wb <= '0;
        end else if (load) begin
            mem_wb_read_data  <= read_data;
            mem_wb_alu_result <= alu_result;
            mem_wb_addr       <= addr;
            mem_wb_wb         <= wb;
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM pipeline stage: issues single data-memory accesses with a bounded wait,
// stalls upstream while waiting and feeds the MEM/WB register bank.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ex_mem_alu_result,
    input  logic [31:0] ex_mem_rtdata,
    input  logic [4:0]  ex_mem_addr,
    input  logic [1:0]  ex_mem_m,
    input  logic [1:0]  ex_mem_wb,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        mem_error,
    output logic [31:0] mem_wb_read_data,
    output logic [31:0] mem_wb_alu_result,
    output logic [4:0]  mem_wb_addr,
    output logic [1:0]  mem_wb_wb
);

    state_t           state;
    logic [CNT_W-1:0] access_cnt;
    logic [4:0]       addr_q;
    logic [1:0]       wb_q;

    logic is_read, is_write, mem_op, illegal_op, ack_hit, timeout_hit;
    logic load, bubble;
    logic [31:0] next_read_data, next_alu_result;
    logic [4:0]  next_addr;
    logic [1:0]  next_wb;

    assign is_read     = ex_mem_m[M_READ_BIT];
    assign is_write    = ex_mem_m[M_WRITE_BIT];
    assign mem_op      = is_read ^ is_write;
    assign illegal_op  = is_read & is_write;
    assign ack_hit     = (state == ACCESS) && dmem_ack;
    // Fires in the TIMEOUT-th ACCESS cycle; an ack in that same cycle wins.
    assign timeout_hit = (state == ACCESS) && !dmem_ack &&
                         (access_cnt == CNT_W'(TIMEOUT - 1));

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        mem_stall       = 1'b0;
        load            = 1'b0;
        next_read_data  = '0;
        next_alu_result = ex_mem_alu_result;
        next_addr       = ex_mem_addr;
        next_wb         = ex_mem_wb;
        if (state == IDLE) begin
            mem_stall = mem_op;
            load      = !mem_op && !illegal_op;
        end else begin
            mem_stall       = !dmem_ack && !timeout_hit;
            load            = dmem_ack;
            next_read_data  = dmem_we ? 32'd0 : dmem_rdata;
            next_alu_result = dmem_addr;
            next_addr       = addr_q;
            next_wb         = wb_q;
        end
    end

    assign bubble = !load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            access_cnt <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            addr_q     <= '0;
            wb_q       <= '0;
            mem_error  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        state      <= ACCESS;
                        access_cnt <= '0;
                        dmem_req   <= 1'b1;
                        dmem_we    <= is_write;
                        dmem_addr  <= ex_mem_alu_result;
                        dmem_wdata <= ex_mem_rtdata;
                        addr_q     <= ex_mem_addr;
                        wb_q       <= ex_mem_wb;
                    end else if (illegal_op) begin
                        mem_error <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (ack_hit || timeout_hit) begin
                        state    <= IDLE;
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (timeout_hit) mem_error <= 1'b1;
                    end else begin
                        access_cnt <= access_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk               (clk),
        .rst               (rst),
        .load              (load),
        .bubble            (bubble),
        .read_data         (next_read_data),
        .alu_result        (next_alu_result),
        .addr              (next_addr),
        .wb                (next_wb),
        .mem_wb_read_data  (mem_wb_read_data),
        .mem_wb_alu_result (mem_wb_alu_result),
        .mem_wb_addr       (mem_wb_addr),
        .mem_wb_wb         (mem_wb_wb)
    );

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock, sole clock domain.
REQ-002 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: ex_mem_alu_result  in  32  address, or pass-through result; ex_mem_rtdata  in  32  store data; ex_mem_addr  in  5  destination register.
REQ-004 SHALL have ports: ex_mem_m  in  2  bit1 MemRead, bit0 MemWrite; ex_mem_wb  in  2  bit1 RegWrite, bit0 MemtoReg.
REQ-005 SHALL have ports: dmem_req  out  1; dmem_we  out  1; dmem_addr  out  32; dmem_wdata  out  32; dmem_ack  in  1; dmem_rdata  in  32.
REQ-006 SHALL have ports: mem_stall  out  1  hold EX/MEM and earlier stages; mem_error  out  1  sticky fault flag.
REQ-007 SHALL have ports: mem_wb_read_data  out  32; mem_wb_alu_result  out  32; mem_wb_addr  out  5; mem_wb_wb  out  2.
REQ-008 SHALL have parameter TIMEOUT, default 15, meaning the maximum number of ACCESS cycles allowed without dmem_ack.

Function
REQ-009 SHALL implement a 2-state FSM: IDLE and ACCESS.
REQ-010 In IDLE with ex_mem_m=00, SHALL register alu_result, addr and wb into MEM_WB on the next edge, with read_data=0 (1-cycle latency) and mem_stall=0.
REQ-011 In IDLE with ex_mem_m=10 or 01, SHALL latch address, wdata and we (=m[0]), enter ACCESS at the next edge, and load bubble (mem_wb_wb=00) into MEM_WB.
REQ-012 mem_stall SHALL be combinational: 1 when (IDLE and m in {10,01}) or (ACCESS and dmem_ack=0); else 0.
REQ-013 In ACCESS, dmem_req SHALL be 1, driven from registers; dmem_addr, dmem_wdata and dmem_we SHALL stay stable until the ack edge.
REQ-014 On dmem_ack=1 in ACCESS, SHALL load read_data=dmem_rdata (0 for writes), alu_result, addr and wb into MEM_WB, and return to IDLE; dmem_req SHALL drop in the following cycle.
REQ-015 The minimum memory-op latency SHALL be 2 edges: the request edge, then the ack edge with ack in the first ACCESS cycle.
REQ-016 SHALL ignore dmem_ack in IDLE.
REQ-017 A 4-bit counter SHALL count ACCESS cycles; if the count reaches TIMEOUT without ack, the FSM SHALL return to IDLE, load a bubble, set mem_error, and deassert mem_stall in that cycle.
REQ-018 ex_mem_m=11 in IDLE SHALL be illegal: no memory access, bubble loaded, mem_error set, mem_stall=0.
REQ-019 mem_error SHALL remain 1 until rst.
REQ-020 While mem_stall=1, each edge SHALL load a bubble (mem_wb_wb=00) so the WB stage performs no duplicate write.
REQ-021 Ack and timeout in the same cycle SHALL be resolved as ack: normal completion, no error.

Reset
REQ-022 rst=1 SHALL immediately force: state=IDLE, counter=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, all mem_wb_* outputs=0, mem_error=0.
REQ-023 Reset during ACCESS SHALL abandon the transaction; any dmem_ack arriving after release SHALL be ignored.
REQ-024 The first edge after rst deassertion SHALL behave as IDLE.

Structure
REQ-025 A shared package SHALL hold the state encoding, the M/WB bit-position constants and the TIMEOUT default.
REQ-026 The MEM/WB output register bank SHALL be a sub-module mem_wb_reg with load and bubble controls; FSM and counter SHALL stay in mem_wb_stage.

Verification
REQ-027 ALU op: m=00, wb=10, alu=0x0000_00AA, addr=5 -> after 1 edge mem_wb_alu_result=0xAA, mem_wb_addr=5, mem_wb_wb=10; stall never asserted.
REQ-028 Load with 3-cycle ack delay: m=10, alu=0x100, rdata=0xDEADBEEF -> dmem_req high 3 cycles at addr 0x100; stall high 3 cycles; then mem_wb_read_data=0xDEADBEEF with wb=11; bubbles (wb=00) meanwhile.
REQ-029 Store with ack in first ACCESS cycle: m=01, alu=0x20, rt=0x1234 -> dmem_we=1, wdata=0x1234 for one cycle; mem_wb_read_data=0.
REQ-030 Timeout: m=10, ack never sent -> after 15 ACCESS cycles, req drops, mem_error=1, stall drops, mem_wb_wb=00; a following ALU op completes normally.
REQ-031 Illegal op m=11 -> no dmem_req, mem_error=1, mem_wb_wb=00, stall=0.
REQ-032 rst asserted mid-ACCESS, with ack asserted 1 cycle after release -> all outputs 0 immediately, ack ignored, state IDLE.
